// File: rtl/ram_lsu_if.sv
// Request/response handshake bundle between a requester and the ram_lsu load/store sequencer.
interface ram_lsu_if #(
  parameter int ADDR_WIDTH = 9
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ram_lsu.sv
// Byte/half/word load-store sequencer in front of a word-wide RAM; sub-word stores use read-modify-write.
// Optional LSU_MISALIGN_ERR_EN: misaligned or size=11 requests are rejected with resp_err instead of being aligned down.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// READ    | RAM read strobe; capture word for load result or RMW merge
// WRITE   | RAM write strobe with full or merged word
// RESP    | one-cycle response pulse
module ram_lsu #(
  parameter int WORDS = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  ram_lsu_if.slave                 bus,
  output logic [$clog2(WORDS)-1:0] ram_address,
  output logic                     ram_rdenable,
  output logic                     ram_wrenable,
  output logic [31:0]              ram_data_in,
  input  logic [31:0]              ram_data_out
);
  localparam int ADDR_WIDTH = $clog2(WORDS) + 2;
  localparam int WA         = $clog2(WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state;
  logic          we_q;
  logic          sgn_q;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;
  logic [WA-1:0] word_addr_q;
  logic [15:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [1:0]    size_n;
  logic [1:0]    lane_n;
  logic          err_req;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_res;
  logic [31:0]   merged;

  // size=11 behaves as a word; low address bits below the access size are dropped
  always_comb begin
    size_n = bus.req_size;
    lane_n = bus.req_addr[1:0];
    if (size_n == 2'b11) size_n = 2'b10;
    if (size_n == 2'b01)      lane_n[0] = 1'b0;
    else if (size_n == 2'b10) lane_n    = 2'b00;
  end

`ifdef LSU_MISALIGN_ERR_EN
  assign err_req = (bus.req_size == 2'b11) ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
  assign err_req = 1'b0;
`endif

  always_comb begin
    rd_byte = ram_data_out[{lane_q, 3'b000} +: 8];
    rd_half = ram_data_out[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_res = sgn_q ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
      2'b01:   load_res = sgn_q ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
      default: load_res = ram_data_out;
    endcase
    merged = ram_data_out;
    if (size_q == 2'b00)      merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
    else if (size_q == 2'b01) merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      we_q        <= 1'b0;
      sgn_q       <= 1'b0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      word_addr_q <= '0;
      wdata_q     <= 16'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      ram_data_in <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            sgn_q       <= bus.req_signed;
            size_q      <= size_n;
            lane_q      <= lane_n;
            word_addr_q <= bus.req_addr[ADDR_WIDTH-1:2];
            wdata_q     <= bus.req_wdata[15:0];
            if (err_req) begin
              rdata_q <= 32'd0;
              err_q   <= 1'b1;
              state   <= S_RESP;
            end else if (bus.req_we && size_n == 2'b10) begin
              ram_data_in <= bus.req_wdata;
              state       <= S_WRITE;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (we_q) begin
            ram_data_in <= merged;
            state       <= S_WRITE;
          end else begin
            rdata_q <= load_res;
            err_q   <= 1'b0;
            state   <= S_RESP;
          end
        end
        S_WRITE: begin
          rdata_q <= 32'd0;
          err_q   <= 1'b0;
          state   <= S_RESP;
        end
        S_RESP: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == S_IDLE) && reset;
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign ram_address    = word_addr_q;
  assign ram_rdenable   = (state == S_READ);
  assign ram_wrenable   = (state == S_WRITE);
endmodule
